// File: rtl/patch_stream_scheduler.sv
// Frame controller between image load, the patchifier and the patch-embedding front end.
// Optional watchdog on the patchifier wait is enabled by defining PATCH_SCHED_WDOG_EN.
module patch_stream_scheduler #(
  parameter int unsigned PIXEL_WIDTH       = 24,
  parameter int unsigned TOTAL_NUM_PATCHES = 16,
  parameter int unsigned PATCH_VECTOR_SIZE = 256,
  parameter int unsigned PATCH_IDX_W       = 4,
  parameter int unsigned POS_IDX_W         = 8,
  parameter int unsigned WDOG_CYCLES       = 8192,
  parameter int unsigned WDOG_W            = 14
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_req,
  output logic                   frame_ack,
  output logic                   frame_done,
  output logic                   pf_en,
  output logic                   pf_output_taken,
  input  logic [1:0]             pf_state,
  output logic [PATCH_IDX_W-1:0] rd_patch,
  output logic [POS_IDX_W-1:0]   rd_pos,
  input  logic [PIXEL_WIDTH-1:0] rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PIXEL_WIDTH-1:0] out_data,
  output logic [PATCH_IDX_W-1:0] out_patch_idx,
  output logic [POS_IDX_W-1:0]   out_pos_idx,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic                   out_eof,
  output logic                   err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_PF,
    S_SETTLE,
    S_STREAM,
    S_RELEASE
  } state_t;

  localparam logic [1:0] PF_IDLE = 2'b00;
  localparam logic [1:0] PF_DONE = 2'b10;
  localparam logic [PATCH_IDX_W-1:0] LAST_PATCH = PATCH_IDX_W'(TOTAL_NUM_PATCHES - 1);
  localparam logic [POS_IDX_W-1:0]   LAST_POS   = POS_IDX_W'(PATCH_VECTOR_SIZE - 1);

  // Elaboration-time guards on inconsistent parameter overrides.
  if (PATCH_IDX_W != $clog2(TOTAL_NUM_PATCHES)) begin : g_bad_patch_w
    $error("PATCH_IDX_W must equal clog2(TOTAL_NUM_PATCHES)");
  end
  if (POS_IDX_W != $clog2(PATCH_VECTOR_SIZE)) begin : g_bad_pos_w
    $error("POS_IDX_W must equal clog2(PATCH_VECTOR_SIZE)");
  end
  if (WDOG_CYCLES > (2 ** WDOG_W) - 1) begin : g_bad_wdog_w
    $error("WDOG_W too narrow for WDOG_CYCLES");
  end

  state_t                   state_q, state_d;
  logic [PATCH_IDX_W-1:0]   patch_q, patch_d;
  logic [POS_IDX_W-1:0]     pos_q, pos_d;
  logic                     loaded_all_q, loaded_all_d;
  logic                     frame_ack_q, frame_ack_d;
  logic                     frame_done_q, frame_done_d;
  logic                     pf_en_q, pf_en_d;
  logic                     pf_taken_q, pf_taken_d;
  logic                     out_valid_q, out_valid_d;
  logic [PIXEL_WIDTH-1:0]   out_data_q, out_data_d;
  logic [PATCH_IDX_W-1:0]   out_patch_q, out_patch_d;
  logic [POS_IDX_W-1:0]     out_pos_q, out_pos_d;
  logic                     out_sop_q, out_sop_d;
  logic                     out_eop_q, out_eop_d;
  logic                     out_eof_q, out_eof_d;
  logic                     load;
  logic                     accept;

`ifdef PATCH_SCHED_WDOG_EN
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_CYCLES - 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              err_q, err_d;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d      = state_q;
    patch_d      = patch_q;
    pos_d        = pos_q;
    loaded_all_d = loaded_all_q;
    frame_ack_d  = 1'b0;
    frame_done_d = 1'b0;
    pf_en_d      = 1'b0;
    pf_taken_d   = 1'b0;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_patch_d  = out_patch_q;
    out_pos_d    = out_pos_q;
    out_sop_d    = out_sop_q;
    out_eop_d    = out_eop_q;
    out_eof_d    = out_eof_q;
    load         = 1'b0;
    accept       = out_valid_q && out_ready;
`ifdef PATCH_SCHED_WDOG_EN
    wdog_d       = wdog_q;
    err_d        = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (frame_req && (pf_state == PF_IDLE)) begin
          pf_en_d      = 1'b1;
          frame_ack_d  = 1'b1;
          patch_d      = '0;
          pos_d        = '0;
          loaded_all_d = 1'b0;
          state_d      = S_WAIT_PF;
`ifdef PATCH_SCHED_WDOG_EN
          wdog_d       = '0;
          err_d        = 1'b0;
`endif
        end
      end

      S_WAIT_PF: begin
        if (pf_state == PF_DONE) begin
          state_d = S_SETTLE;
        end
`ifdef PATCH_SCHED_WDOG_EN
        else if (wdog_q == WDOG_LIMIT) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
`endif
      end

      // all_patches becomes valid one cycle after the patchifier enters DONE.
      S_SETTLE: state_d = S_STREAM;

      S_STREAM: begin
        load = !loaded_all_q && (!out_valid_q || out_ready);
        if (load) begin
          out_valid_d = 1'b1;
          out_data_d  = rd_data;
          out_patch_d = patch_q;
          out_pos_d   = pos_q;
          out_sop_d   = (pos_q == '0);
          out_eop_d   = (pos_q == LAST_POS);
          out_eof_d   = (pos_q == LAST_POS) && (patch_q == LAST_PATCH);
          if (pos_q == LAST_POS) begin
            pos_d = '0;
            if (patch_q == LAST_PATCH) begin
              patch_d      = '0;
              loaded_all_d = 1'b1;
            end else begin
              patch_d = patch_q + PATCH_IDX_W'(1);
            end
          end else begin
            pos_d = pos_q + POS_IDX_W'(1);
          end
        end else if (accept) begin
          out_valid_d = 1'b0;
        end

        // The eof beat is the last one loaded, so load and this branch never coincide.
        if (accept && out_eof_q) begin
          pf_taken_d   = 1'b1;
          frame_done_d = 1'b1;
          state_d      = S_RELEASE;
        end
      end

      S_RELEASE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      patch_q      <= '0;
      pos_q        <= '0;
      loaded_all_q <= 1'b0;
      frame_ack_q  <= 1'b0;
      frame_done_q <= 1'b0;
      pf_en_q      <= 1'b0;
      pf_taken_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_patch_q  <= '0;
      out_pos_q    <= '0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      out_eof_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      patch_q      <= patch_d;
      pos_q        <= pos_d;
      loaded_all_q <= loaded_all_d;
      frame_ack_q  <= frame_ack_d;
      frame_done_q <= frame_done_d;
      pf_en_q      <= pf_en_d;
      pf_taken_q   <= pf_taken_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_patch_q  <= out_patch_d;
      out_pos_q    <= out_pos_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      out_eof_q    <= out_eof_d;
    end
  end

`ifdef PATCH_SCHED_WDOG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign frame_ack       = frame_ack_q;
  assign frame_done      = frame_done_q;
  assign pf_en           = pf_en_q;
  assign pf_output_taken = pf_taken_q;
  assign rd_patch        = patch_q;
  assign rd_pos          = pos_q;
  assign out_valid       = out_valid_q;
  assign out_data        = out_data_q;
  assign out_patch_idx   = out_patch_q;
  assign out_pos_idx     = out_pos_q;
  assign out_sop         = out_sop_q;
  assign out_eop         = out_eop_q;
  assign out_eof         = out_eof_q;

endmodule

// File: tb/tb_patch_stream_scheduler.sv
// Scoreboard bench for patch_stream_scheduler: a patchifier model publishes a random frame,
// the expected beat list is queued, and a monitor pops and compares every accepted beat.
module tb_patch_stream_scheduler;

  localparam int NP = 16;
  localparam int VS = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_req;
  logic        frame_ack, frame_done, pf_en, pf_output_taken;
  logic [1:0]  pf_state;
  logic [3:0]  rd_patch;
  logic [7:0]  rd_pos;
  logic [23:0] rd_data;
  logic        out_valid, out_ready;
  logic [23:0] out_data;
  logic [3:0]  out_patch_idx;
  logic [7:0]  out_pos_idx;
  logic        out_sop, out_eop, out_eof, err_timeout;

  always #5 clk = ~clk;

  patch_stream_scheduler dut (
    .clk(clk), .reset(reset), .frame_req(frame_req), .frame_ack(frame_ack),
    .frame_done(frame_done), .pf_en(pf_en), .pf_output_taken(pf_output_taken),
    .pf_state(pf_state), .rd_patch(rd_patch), .rd_pos(rd_pos), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_patch_idx(out_patch_idx), .out_pos_idx(out_pos_idx), .out_sop(out_sop),
    .out_eop(out_eop), .out_eof(out_eof), .err_timeout(err_timeout)
  );

  typedef struct packed {
    logic [23:0] data;
    logic [3:0]  patch;
    logic [7:0]  pos;
    logic        sop;
    logic        eop;
    logic        eof;
  } beat_t;

  beat_t sb[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] pix(input logic [31:0] s, input int p, input int q);
    logic [31:0] h;
    h = s ^ (p * 32'h9E3779B1) ^ (q * 32'h7FEB352D);
    h = h ^ (h >> 15);
    h = h * 32'h846CA68B;
    h = h ^ (h >> 16);
    return h[23:0];
  endfunction

  function automatic logic [63:0] all_outs();
    return {frame_ack, frame_done, pf_en, pf_output_taken, rd_patch, rd_pos, out_valid,
            out_data, out_patch_idx, out_pos_idx, out_sop, out_eop, out_eof, err_timeout};
  endfunction

  // Patchifier model
  logic [1:0]  model_state;
  logic        busy_force, stuck, pf_abort, published;
  logic [31:0] seed;
  int          pf_latency, pcnt, done_set_cyc;

  assign pf_state = (busy_force && model_state == 2'b00) ? 2'b01 : model_state;
  assign rd_data  = pix(seed, int'(rd_patch), int'(rd_pos));

  initial begin
    logic en_s, tk_s;
    beat_t b;
    model_state = 2'b00; published = 1'b0; seed = 32'h0; pcnt = 0; done_set_cyc = 0;
    forever begin
      @(negedge clk);
      en_s = pf_en;
      tk_s = pf_output_taken;
      @(posedge clk);
      #1;
      if (reset || pf_abort) begin
        model_state = 2'b00;
        published   = 1'b0;
      end else begin
        case (model_state)
          2'b00: if (en_s) begin model_state = 2'b01; pcnt = 0; end
          2'b01: begin
            pcnt++;
            if (!stuck && pcnt >= pf_latency) begin
              model_state  = 2'b10;
              done_set_cyc = cyc;
            end
          end
          2'b10: begin
            if (!published) begin
              seed      = $urandom;
              published = 1'b1;
              for (int p = 0; p < NP; p++) begin
                for (int q = 0; q < VS; q++) begin
                  b.data  = pix(seed, p, q);
                  b.patch = p[3:0];
                  b.pos   = q[7:0];
                  b.sop   = (q == 0);
                  b.eop   = (q == VS - 1);
                  b.eof   = (p == NP - 1) && (q == VS - 1);
                  sb.push_back(b);
                end
              end
            end else if (tk_s) begin
              model_state = 2'b00;
              published   = 1'b0;
            end
          end
          default: model_state = 2'b00;
        endcase
      end
    end
  end

  // Downstream ready
  logic ready_all;
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = ready_all ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Monitor
  int    beats_in_frame = 0, ack_pulses = 0, en_pulses = 0, done_pulses = 0, taken_pulses = 0;
  int    last_ack_cyc = 0, last_done_cyc = 0, last_eof_cyc = 0, first_valid_cyc = 0;
  logic  first_valid_seen = 1'b0, prev_stall = 1'b0;
  beat_t prev_beat;

  initial begin
    beat_t cur, exp_b;
    forever begin
      @(negedge clk);
      if (reset) begin
        beats_in_frame = 0;
        prev_stall     = 1'b0;
        continue;
      end
      cur = {out_data, out_patch_idx, out_pos_idx, out_sop, out_eop, out_eof};
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_hold", cur, prev_beat);
      end
      if (out_valid && !first_valid_seen) begin
        first_valid_seen = 1'b1;
        first_valid_cyc  = cyc;
        check("first_valid_latency", cyc, done_set_cyc + 3);
      end
      if (out_valid && out_ready) begin
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp_b = sb.pop_front();
          check("beat", cur, exp_b);
        end
        beats_in_frame++;
        if (out_eof) begin
          check("frame_beats", beats_in_frame, NP * VS);
          beats_in_frame = 0;
          last_eof_cyc   = cyc;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = cur;
      if (frame_ack || pf_en) check("en_with_ack", pf_en, frame_ack);
      if (pf_en) en_pulses++;
      if (frame_ack) begin
        ack_pulses++;
        last_ack_cyc     = cyc;
        first_valid_seen = 1'b0;
        check("err_clear_on_ack", err_timeout, 0);
      end
      if (frame_done || pf_output_taken) begin
        check("done_with_taken", frame_done, pf_output_taken);
        check("release_latency", cyc, last_eof_cyc + 1);
        if (frame_done) begin done_pulses++; last_done_cyc = cyc; end
        if (pf_output_taken) taken_pulses++;
      end
    end
  end

  task automatic wait_ack(input int budget);
    int a0 = ack_pulses;
    logic got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (ack_pulses != a0) begin got = 1'b1; break; end
    end
    check("ack_seen", got, 1);
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_pulses;
    logic got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_pulses != d0) begin got = 1'b1; break; end
    end
    check("done_seen", got, 1);
  endtask

  task automatic start_frame();
    @(posedge clk); #1;
    frame_req = 1'b1;
    wait_ack(200);
    @(posedge clk); #1;
    frame_req = 1'b0;
  endtask

  initial begin
    int frames_exp = 0;
    int en0, a0, t0, rel_cyc, err_cyc;
    logic hit;
    reset = 1'b1; frame_req = 1'b0; busy_force = 1'b0; stuck = 1'b0; pf_abort = 1'b0;
    pf_latency = 4100; ready_all = 1'b1;
    #2;
    check("reset_outputs", all_outs(), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Full-throughput frame
    start_frame();
    wait_done(20000);
    frames_exp++;
    check("f1_contiguous", last_eof_cyc - first_valid_cyc, NP * VS - 1);
    check("f1_sb_empty", sb.size(), 0);

    // Random backpressure with frame_req held through stream and release
    ready_all = 1'b0; pf_latency = 30;
    @(posedge clk); #1;
    frame_req = 1'b1;
    wait_ack(200);
    en0 = en_pulses;
    wait_done(20000);
    frames_exp++;
    wait_ack(50);
    check("held_req_ack_gap", last_ack_cyc, last_done_cyc + 2);
    check("no_extra_en", en_pulses, en0 + 1);
    @(posedge clk); #1;
    frame_req = 1'b0;
    wait_done(20000);
    frames_exp++;

    // Patchifier busy while idle
    ready_all = 1'b1;
    @(posedge clk); #1; busy_force = 1'b1;
    @(posedge clk); #1; frame_req = 1'b1;
    a0 = ack_pulses; en0 = en_pulses;
    repeat (20) @(negedge clk);
    check("busy_no_ack", ack_pulses, a0);
    check("busy_no_en", en_pulses, en0);
    @(posedge clk); #1;
    busy_force = 1'b0;
    rel_cyc = cyc;
    wait_ack(50);
    check("busy_release_ack", last_ack_cyc, rel_cyc + 1);
    @(posedge clk); #1; frame_req = 1'b0;
    wait_done(20000);
    frames_exp++;

    // Reset in the middle of streaming
    ready_all = 1'b0;
    start_frame();
    hit = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk); #2;
      if (beats_in_frame >= 1000) begin hit = 1'b1; break; end
    end
    check("reached_beat_1000", hit, 1);
    t0 = taken_pulses;
    reset = 1'b1;
    #1;
    check("reset_async_outputs", all_outs(), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_no_taken", taken_pulses, t0);

    start_frame();
    wait_done(20000);
    frames_exp++;
    check("post_reset_sb_empty", sb.size(), 0);

`ifdef PATCH_SCHED_WDOG_EN
    stuck = 1'b1;
    t0 = taken_pulses;
    start_frame();
    hit = 1'b0; err_cyc = 0;
    for (int i = 0; i < 9000; i++) begin
      @(negedge clk); #1;
      if (err_timeout) begin hit = 1'b1; err_cyc = cyc; break; end
    end
    check("wdog_fired", hit, 1);
    check("wdog_latency", err_cyc, last_ack_cyc + 8192);
    check("wdog_no_taken", taken_pulses, t0);
    @(negedge clk); stuck = 1'b0; pf_abort = 1'b1;
    repeat (2) @(negedge clk);
    pf_abort = 1'b0;
    start_frame();
    check("wdog_err_cleared", err_timeout, 0);
    wait_done(20000);
    frames_exp++;
`endif

    repeat (5) @(negedge clk);
    check("taken_count", taken_pulses, frames_exp);
    check("final_sb_empty", sb.size(), 0);
    check("err_idle", err_timeout, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
